spi_master_ctrl: RTL and testbench

- Command-side SPI master that generates frames for the team's SPI slave + single-port RAM subsystem.
- Takes 2-bit command + 8-bit payload over a valid/ready handshake and serialises it on MOSI with SS_n framing, one bit per clk.
- For read-data commands it samples 8 MISO bits and returns them on a response port.
- Sits between the test/host logic and the SPI slave, on the same clock (no SCLK division).

---
 rtl/spi_master_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   Command-side SPI master for the SPI slave + single-port RAM subsystem.
//   It accepts a 2-bit command and an 8-bit payload over a valid/ready
//   handshake. It sends the 10-bit frame MSB first on MOSI, one bit per clk,
//   framed by SS_n. For a read-data command it then captures 8 MISO bits and
//   returns them on the response port.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active high
//   cmd_valid  command request
//   cmd_ready  command can be accepted (high only in IDLE)
//   cmd_type   00 write-addr, 01 write-data, 10 read-addr, 11 read-data
//   cmd_data   address / write data (don't-care for read-data)
//   rsp_valid  one-clk pulse, rsp_data valid
//   rsp_data   byte captured from MISO
//   busy       high whenever the FSM is not in IDLE
//   seq_err    only with SPI_MASTER_SEQ_CHECK_EN: read-data issued with no
//              preceding read-addr
//   SS_n       slave select, active low, registered
//   MOSI       serial data to slave, registered
//   MISO       serial data from slave
//
// Optional build macro: SPI_MASTER_SEQ_CHECK_EN
//   When it is defined, the master tracks whether a read-addr frame has been
//   sent. A read-data command that arrives without one sends no frame. It
//   returns 8'hFF with seq_err set instead.
//
// TAIL_CYCLES, RD_LATENCY and GAP_CYCLES must each be at least 1.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | SS_n high, cmd_ready high, waiting for a command
// S_START    | SS_n low, MOSI 0
// S_CMD      | MOSI = frame[9] (slave write/read select)
// S_SHIFT    | MOSI = frame[9..0], 10 clks, counter 10 -> 1
// S_TAIL     | SS_n held low TAIL_CYCLES so the slave can flag rx_valid
// S_RD_WAIT  | SS_n low, RD_LATENCY clks before the first MISO sample
// S_RD_SHIFT | 8 MISO samples MSB first, then rsp_valid
// S_GAP      | SS_n high for GAP_CYCLES between frames
module spi_master_ctrl #(
  parameter int TAIL_CYCLES = 2,
  parameter int RD_LATENCY  = 3,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
`ifdef SPI_MASTER_SEQ_CHECK_EN
  output logic       seq_err,
`endif
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_CMD, S_SHIFT, S_TAIL, S_RD_WAIT, S_RD_SHIFT, S_GAP
  } state_t;

  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  localparam logic [7:0] SHIFT_LD    = 8'd10;
  localparam logic [7:0] RDSH_LD     = 8'd8;
  localparam logic [7:0] TAIL_LD     = 8'(TAIL_CYCLES);
  localparam logic [7:0] RDW_LD      = 8'(RD_LATENCY);
  localparam logic [7:0] GAP_LD      = 8'(GAP_CYCLES);

  state_t      state_q, state_n;
  logic [7:0]  cnt_q, cnt_n;
  logic [9:0]  frame_q, frame_n;
  logic [6:0]  sr_q, sr_n;
  logic        ss_n_n, mosi_n, rsp_valid_n;
  logic [7:0]  rsp_data_n;
  logic [3:0]  bit_idx;
`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic        flag_q, flag_n, seq_err_n;
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    frame_n     = frame_q;
    sr_n        = sr_q;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data;
    ss_n_n      = 1'b1;
    mosi_n      = 1'b0;
    bit_idx     = 4'd0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    flag_n      = flag_q;
    seq_err_n   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          frame_n = {cmd_type, cmd_data};
          state_n = S_START;
`ifdef SPI_MASTER_SEQ_CHECK_EN
          // Out-of-order read-data: answer immediately and never touch the bus.
          if (cmd_type == CMD_RD_DATA && !flag_q) begin
            state_n     = S_GAP;
            cnt_n       = GAP_LD;
            rsp_valid_n = 1'b1;
            rsp_data_n  = 8'hFF;
            seq_err_n   = 1'b1;
          end
`endif
        end
      end
      S_START: state_n = S_CMD;
      S_CMD: begin
        state_n = S_SHIFT;
        cnt_n   = SHIFT_LD;
      end
      S_SHIFT: begin
        if (cnt_q == 8'd1) begin
          if (frame_q[9:8] == CMD_RD_DATA) begin
            state_n = S_RD_WAIT;
            cnt_n   = RDW_LD;
          end else begin
            state_n = S_TAIL;
            cnt_n   = TAIL_LD;
          end
        end else begin
          cnt_n = cnt_q - 8'd1;
        end
      end
      S_TAIL: begin
        if (cnt_q == 8'd1) begin
          state_n = S_GAP;
          cnt_n   = GAP_LD;
`ifdef SPI_MASTER_SEQ_CHECK_EN
          if (frame_q[9:8] == CMD_RD_ADDR) flag_n = 1'b1;
`endif
        end else begin
          cnt_n = cnt_q - 8'd1;
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == 8'd1) begin
          state_n = S_RD_SHIFT;
          cnt_n   = RDSH_LD;
        end else begin
          cnt_n = cnt_q - 8'd1;
        end
      end
      S_RD_SHIFT: begin
        sr_n = {sr_q[5:0], MISO};
        if (cnt_q == 8'd1) begin
          state_n     = S_GAP;
          cnt_n       = GAP_LD;
          rsp_valid_n = 1'b1;
          rsp_data_n  = {sr_q, MISO};
`ifdef SPI_MASTER_SEQ_CHECK_EN
          flag_n      = 1'b0;
`endif
        end else begin
          cnt_n = cnt_q - 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 8'd1) begin
          state_n = S_IDLE;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt_q - 8'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 8'd0;
      end
    endcase

    // SS_n and MOSI are decoded from the next state so that, once registered,
    // they line up with the state they belong to.
    ss_n_n = !(state_n inside {S_START, S_CMD, S_SHIFT, S_TAIL, S_RD_WAIT, S_RD_SHIFT});
    if (state_n == S_CMD) begin
      mosi_n = frame_n[9];
    end else if (state_n == S_SHIFT) begin
      bit_idx = cnt_n[3:0] - 4'd1;
      mosi_n  = frame_n[bit_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      frame_q   <= 10'd0;
      sr_q      <= 7'd0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'd0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
      flag_q    <= 1'b0;
      seq_err   <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      frame_q   <= frame_n;
      sr_q      <= sr_n;
      SS_n      <= ss_n_n;
      MOSI      <= mosi_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
`ifdef SPI_MASTER_SEQ_CHECK_EN
      flag_q    <= flag_n;
      seq_err   <= seq_err_n;
`endif
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: driver pushes expected frames/responses into
// queues at accept time; monitors pop and compare as the DUT produces them.
module tb_spi_master_ctrl;

  localparam int TAIL_CYCLES = 2;
  localparam int RD_LATENCY  = 3;
  localparam int GAP_CYCLES  = 1;
  localparam int WR_LOW      = 1 + 1 + 10 + TAIL_CYCLES;
  localparam int RD_LOW      = 1 + 1 + 10 + RD_LATENCY + 8;
  localparam int RD_RSP_LAT  = 1 + 1 + 10 + RD_LATENCY + 8;
  localparam int WR_IDLE_LAT = 1 + 1 + 10 + TAIL_CYCLES + GAP_CYCLES;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_type = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       MISO = 1'b0;
  logic       cmd_ready, rsp_valid, busy, SS_n, MOSI;
  logic [7:0] rsp_data;
`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic       seq_err;
`endif

  spi_master_ctrl #(
    .TAIL_CYCLES(TAIL_CYCLES), .RD_LATENCY(RD_LATENCY), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy),
`ifdef SPI_MASTER_SEQ_CHECK_EN
    .seq_err(seq_err),
`endif
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct { logic [10:0] bits; int len; } frm_t;
  typedef struct { logic [7:0] data; int lat; logic serr; int acc; } rsp_t;

  frm_t sb_q[$];
  rsp_t rsp_q[$];

  logic [7:0] slv_byte = 8'h00;
  bit         chk_gap = 1'b0;
  bit         abort_pending = 1'b0;

  // Slave model: drives the response byte MSB first during the 8 clks that
  // follow START+CMD+10 SHIFT+RD_LATENCY after SS_n falls.
  int slv_cnt = 0;
  always @(negedge clk) begin
    if (!SS_n) begin
      if (slv_cnt >= 12 + RD_LATENCY && slv_cnt < 20 + RD_LATENCY)
        MISO = slv_byte[19 + RD_LATENCY - slv_cnt];
      else
        MISO = 1'b0;
      slv_cnt++;
    end else begin
      slv_cnt = 0;
      MISO = 1'b0;
    end
  end

  // Frame monitor: captures CMD + SHIFT bits and the SS_n low length.
  int          lowcnt = 0;
  bit          was_low = 1'b0;
  int          rise_cyc = 0;
  logic [10:0] cap = '0;
  frm_t        fe;
  always @(negedge clk) begin
    if (!SS_n) begin
      if (lowcnt == 0) begin
        check("mosi_start", MOSI, 1'b0);
        if (chk_gap) begin
          check("ss_gap", cyc_cnt - rise_cyc, GAP_CYCLES + 1);
          chk_gap = 1'b0;
        end
      end else if (lowcnt <= 11) begin
        cap[11 - lowcnt] = MOSI;
      end
      lowcnt++;
      was_low = 1'b1;
    end else if (was_low) begin
      rise_cyc = cyc_cnt;
      if (abort_pending) begin
        abort_pending = 1'b0;
      end else begin
        check("frame_sb", sb_q.size() > 0, 1'b1);
        if (sb_q.size() > 0) begin
          fe = sb_q.pop_front();
          check("frame_bits", cap, fe.bits);
          check("ss_low_len", lowcnt, fe.len);
        end
      end
      was_low = 1'b0;
      lowcnt  = 0;
    end
  end

  // Response monitor.
  bit   prev_rv = 1'b0;
  rsp_t re;
  always @(negedge clk) begin
    if (rsp_valid) begin
      check("rsp_pulse", prev_rv, 1'b0);
      check("rsp_sb", rsp_q.size() > 0, 1'b1);
      if (rsp_q.size() > 0) begin
        re = rsp_q.pop_front();
        check("rsp_data", rsp_data, re.data);
        if (re.lat >= 0) check("rsp_lat", cyc_cnt - re.acc, re.lat);
`ifdef SPI_MASTER_SEQ_CHECK_EN
        check("seq_err", seq_err, re.serr);
`endif
      end
    end
    prev_rv = rsp_valid;
  end

  function automatic logic [10:0] mk_bits(input logic [1:0] t, input logic [7:0] d);
    return {t[1], t, d};
  endfunction

  task automatic send_cmd(input logic [1:0] t, input logic [7:0] d, input bit serr,
                          output int acc);
    int   n = 0;
    frm_t f;
    rsp_t r;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_data  = d;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_to", n < 100, 1'b1);
    acc = cyc_cnt + 1;
    if (serr) begin
      r = '{data: 8'hFF, lat: -1, serr: 1'b1, acc: acc};
      rsp_q.push_back(r);
    end else begin
      f = '{bits: mk_bits(t, d), len: (t == 2'b11) ? RD_LOW : WR_LOW};
      sb_q.push_back(f);
      if (t == 2'b11) begin
        r = '{data: slv_byte, lat: RD_RSP_LAT, serr: 1'b0, acc: acc};
        rsp_q.push_back(r);
      end
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_to", n < 200, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, acc_a, acc_b, n, na, rv_cnt;
    int accs[2];
    logic [7:0] d;
    bit ss_hi;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ss_n", SS_n, 1'b1);
    check("rst_mosi", MOSI, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    rst = 1'b0;

`ifdef SPI_MASTER_SEQ_CHECK_EN
    // Read-data with no prior read-addr: no frame, error response.
    send_cmd(2'b11, 8'h00, 1'b1, acc);
    ss_hi = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (!SS_n) ss_hi = 1'b0;
    end
    check("seqerr_ss_high", ss_hi, 1'b1);
    wait_idle();
`endif

    // Write-addr 00/3C with accept-to-ready latency.
    send_cmd(2'b00, 8'h3C, 1'b0, acc);
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_lat", cyc_cnt - acc, WR_IDLE_LAT);

    // Write-addr then write-data back to back.
    send_cmd(2'b00, 8'h3C, 1'b0, acc_a);
    @(negedge clk);
    #1 chk_gap = 1'b1;
    send_cmd(2'b01, 8'hA5, 1'b0, acc_b);
    check("b2b_accept", acc_b - acc_a, WR_IDLE_LAT + 1);
    wait_idle();

    // Read-addr then read-data, slave returns A5.
    send_cmd(2'b10, 8'h3C, 1'b0, acc);
    slv_byte = 8'hA5;
    send_cmd(2'b11, 8'h00, 1'b0, acc);
    wait_idle();

    // Second read pair with a different byte.
    send_cmd(2'b10, 8'h5A, 1'b0, acc);
    slv_byte = 8'h3C;
    send_cmd(2'b11, 8'hC3, 1'b0, acc);
    wait_idle();

    // cmd_valid held high with changing data: only IDLE accepts latch data.
    na = 0;
    n  = 0;
    accs[0] = 0;
    accs[1] = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_type  = 2'b01;
    while (na < 2 && n < 100) begin
      d = 8'($urandom);
      cmd_data = d;
      if (cmd_ready) begin
        sb_q.push_back('{bits: mk_bits(2'b01, d), len: WR_LOW});
        accs[na] = cyc_cnt + 1;
        na++;
      end
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    check("held_accepts", na, 2);
    check("held_acc_gap", accs[1] - accs[0], WR_IDLE_LAT + 1);
    wait_idle();

    // Reset mid-SHIFT of a read-data frame.
    send_cmd(2'b10, 8'h11, 1'b0, acc);
    slv_byte = 8'h96;
    send_cmd(2'b11, 8'h00, 1'b0, acc);
    repeat (5) @(negedge clk);
    abort_pending = 1'b1;
    sb_q.delete();
    rsp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check("abort_ss_n", SS_n, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", cmd_ready, 1'b1);
    check("abort_mosi", MOSI, 1'b0);
    rv_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) rv_cnt++;
    end
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) rv_cnt++;
    end
    check("abort_no_rsp", rv_cnt, 0);

    // Recovery after reset.
    send_cmd(2'b01, 8'h0F, 1'b0, acc);
    wait_idle();
    repeat (5) @(negedge clk);

    check("sb_drained", sb_q.size(), 0);
    check("rsp_drained", rsp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
